bram_latency_ctrl: RTL and testbench

BRAM_LATENCY_CTRL -- requirements
Module: bram_latency_ctrl

---
 rtl/bram_ctrl_pkg.sv | 28 ++
 rtl/bram_bytewise.sv | 37 +++
 rtl/bram_latency_ctrl.sv | 155 +++++++++++++++
 tb/tb_bram_latency_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_ctrl_pkg.sv
// Shared constants, requester ids and width helpers for the BRAM latency controller.
package bram_ctrl_pkg;

    // Default geometry and pipeline depth
    localparam int unsigned DEF_ADDR_W  = 13;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_LATENCY = 10;
    localparam int unsigned DEF_NUM_REQ = 3;
    localparam int unsigned DEF_MAX_OUT = 8;

    // Requester channels sharing the memory
    typedef enum logic [1:0] {
        REQ_DMA  = 2'd0,
        REQ_CPU  = 2'd1,
        REQ_PRED = 2'd2
    } req_src_e;

    // Width of a requester id; at least one bit even for a single channel
    function automatic int unsigned id_width(input int unsigned num_req);
        return (num_req <= 1) ? 1 : $clog2(num_req);
    endfunction

    // Width of a counter that must hold 0..max_out inclusive
    function automatic int unsigned count_width(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/bram_bytewise.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module bram_bytewise
    import bram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    localparam int unsigned BE_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // One access per cycle: strobed byte write, or read into the output register
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned b = 0; b < BE_W; b++) begin
                    if (be[b]) begin
                        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/bram_latency_ctrl.sv
// Fixed-latency BRAM front end: requests travel an in-order delay line, touch
// the RAM at its tail, and reads return exactly LATENCY cycles after accept.
module bram_latency_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned LATENCY = DEF_LATENCY,
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned MAX_OUT = DEF_MAX_OUT,
    localparam int unsigned ID_W   = id_width(NUM_REQ),
    localparam int unsigned BE_W   = DATA_W / 8,
    localparam int unsigned OUT_W  = count_width(MAX_OUT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_we,
    input  logic [BE_W-1:0]    in_be,
    input  logic [ADDR_W-1:0]  in_addr,
    input  logic [DATA_W-1:0]  in_wdata,
    input  logic [ID_W-1:0]    in_id,
    output logic               rsp_valid,
    output logic [ID_W-1:0]    rsp_id,
    output logic [NUM_REQ-1:0] rsp_vec,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic [OUT_W-1:0]   outstanding,
    output logic               busy
);

    // Stage LAST drives the RAM; its registered read plus the response
    // register make up the remaining cycle of latency.
    localparam int unsigned STAGES = LATENCY - 1;
    localparam int unsigned LAST   = STAGES - 1;
    localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);

    logic accept;
    logic rd_accept;

    logic              st_valid [STAGES];
    logic              st_we    [STAGES];
    logic [BE_W-1:0]   st_be    [STAGES];
    logic [ADDR_W-1:0] st_addr  [STAGES];
    logic [DATA_W-1:0] st_wdata [STAGES];
    logic [ID_W-1:0]   st_id    [STAGES];

    logic              pend_valid;
    logic [ID_W-1:0]   pend_id;
    logic [DATA_W-1:0] mem_rdata;
    logic [NUM_REQ-1:0] vec_next;

    // Ready depends only on the registered count, never on in_valid
    assign in_ready  = (outstanding < MAX_OUT_C);
    assign accept    = in_valid & in_ready;
    assign rd_accept = accept & ~in_we;

    // In-order delay line; reset drops every in-flight request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                st_valid[i] <= 1'b0;
                st_we[i]    <= 1'b0;
                st_be[i]    <= '0;
                st_addr[i]  <= '0;
                st_wdata[i] <= '0;
                st_id[i]    <= '0;
            end
        end else begin
            st_valid[0] <= accept;
            st_we[0]    <= in_we;
            st_be[0]    <= in_be;
            st_addr[0]  <= in_addr;
            st_wdata[0] <= in_wdata;
            st_id[0]    <= in_id;
            for (int unsigned i = 1; i < STAGES; i++) begin
                st_valid[i] <= st_valid[i-1];
                st_we[i]    <= st_we[i-1];
                st_be[i]    <= st_be[i-1];
                st_addr[i]  <= st_addr[i-1];
                st_wdata[i] <= st_wdata[i-1];
                st_id[i]    <= st_id[i-1];
            end
        end
    end

    bram_bytewise #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .en    (st_valid[LAST]),
        .we    (st_we[LAST]),
        .be    (st_be[LAST]),
        .addr  (st_addr[LAST]),
        .wdata (st_wdata[LAST]),
        .rdata (mem_rdata)
    );

    // Track a read while the RAM output register is being loaded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_id    <= '0;
        end else begin
            pend_valid <= st_valid[LAST] & ~st_we[LAST];
            pend_id    <= st_id[LAST];
        end
    end

    // One-hot requester decode; ids beyond NUM_REQ decode to all zeros
    always_comb begin
        vec_next = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            vec_next[r] = pend_valid && (pend_id == ID_W'(r));
        end
    end

    // Response register: one-cycle pulse with id, decode and data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_vec   <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= pend_valid;
            rsp_id    <= pend_id;
            rsp_vec   <= vec_next;
            rsp_rdata <= mem_rdata;
        end
    end

    // Reads in flight: up on read accept, down as each response leaves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({rd_accept, rsp_valid})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Busy while anything sits in the delay line or a read awaits its data
    always_comb begin
        busy = pend_valid;
        for (int unsigned i = 0; i < STAGES; i++) begin
            busy = busy | st_valid[i];
        end
    end

endmodule

// File: tb/tb_bram_latency_ctrl.sv
// Bench for bram_latency_ctrl: three instances (LATENCY 10, 2, 32) checked
// against a transaction-level memory/ordering model.
module tb_bram_latency_ctrl;
    import bram_ctrl_pkg::*;

    localparam int NDUT = 3;

    function automatic int unsigned lat_of(input int g);
        case (g)
            1:       return 2;
            2:       return 32;
            default: return 10;
        endcase
    endfunction

    function automatic int unsigned mout_of(input int g);
        return (g == 1) ? 2 : 8;
    endfunction

    function automatic logic [31:0] pre(input int unsigned a);
        return 32'hA5A5_0000 | a;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    typedef struct {
        int unsigned k;
        logic        we;
        logic [12:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [1:0]  id;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned cyc = 0;

    logic [NDUT-1:0]       in_valid, in_we, in_ready, rsp_valid, busy;
    logic [NDUT-1:0][3:0]  in_be, outstanding;
    logic [NDUT-1:0][12:0] in_addr;
    logic [NDUT-1:0][31:0] in_wdata, rsp_rdata;
    logic [NDUT-1:0][1:0]  in_id, rsp_id;
    logic [NDUT-1:0][2:0]  rsp_vec;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned L  = lat_of(g);
        localparam int unsigned MO = mout_of(g);
        localparam int unsigned OW = $clog2(MO + 1);

        logic [OW-1:0] outs_w;
        assign outstanding[g] = 4'(outs_w);

        bram_latency_ctrl #(
            .ADDR_W  (13),
            .DATA_W  (32),
            .LATENCY (L),
            .NUM_REQ (3),
            .MAX_OUT (MO)
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .in_valid    (in_valid[g]),
            .in_ready    (in_ready[g]),
            .in_we       (in_we[g]),
            .in_be       (in_be[g]),
            .in_addr     (in_addr[g]),
            .in_wdata    (in_wdata[g]),
            .in_id       (in_id[g]),
            .rsp_valid   (rsp_valid[g]),
            .rsp_id      (rsp_id[g]),
            .rsp_vec     (rsp_vec[g]),
            .rsp_rdata   (rsp_rdata[g]),
            .outstanding (outs_w),
            .busy        (busy[g])
        );

        logic [31:0] mem [int unsigned];
        op_t rq[$];
        op_t pw[$];
        op_t ops[$];
        logic [31:0] last_rdata = '0;
        logic [1:0]  last_id = '0;
        logic [2:0]  last_vec = '0;
        int unsigned last_lat = 0;
        int unsigned peak = 0;

        // Model: writes land LATENCY-1 edges after accept; reads see all earlier writes
        always @(negedge clk) begin : mon
            op_t e;
            logic [31:0] d;
            logic bexp;
            string p;
            p = $sformatf("d%0d_", g);
            while (pw.size() > 0 && pw[0].k + L - 1 <= cyc) begin
                e = pw.pop_front();
                d = mem.exists(int'(e.addr)) ? mem[int'(e.addr)] : 32'h0;
                mem[int'(e.addr)] = merge(d, e.data, e.be);
            end
            if (rst) begin
                pw.delete();
                rq.delete();
                ops.delete();
                peak = 0;
                chk({p, "rst_valid"}, 64'(rsp_valid[g]), 64'(0));
                chk({p, "rst_vec"},   64'(rsp_vec[g]),   64'(0));
                chk({p, "rst_id"},    64'(rsp_id[g]),    64'(0));
                chk({p, "rst_out"},   64'(outstanding[g]), 64'(0));
                chk({p, "rst_busy"},  64'(busy[g]),      64'(0));
                chk({p, "rst_ready"}, 64'(in_ready[g]),  64'(1));
            end else begin
                chk({p, "outstanding"}, 64'(outstanding[g]), 64'(rq.size()));
                chk({p, "in_ready"}, 64'(in_ready[g]), 64'(rq.size() < MO));
                while (ops.size() > 0 && ops[0].k + L < cyc) void'(ops.pop_front());
                bexp = 1'b0;
                foreach (ops[i]) if (cyc <= ops[i].k + L - 2 + (ops[i].we ? 0 : 1)) bexp = 1'b1;
                chk({p, "busy"}, 64'(busy[g]), 64'(bexp));
                if (int'(outstanding[g]) > int'(peak)) peak = outstanding[g];
                if (rsp_valid[g]) begin
                    if (rq.size() == 0) begin
                        chk({p, "unexpected_rsp"}, 64'(1), 64'(0));
                    end else begin
                        e = rq.pop_front();
                        chk({p, "latency"}, 64'(cyc - e.k), 64'(L));
                        chk({p, "rsp_id"},  64'(rsp_id[g]),  64'(e.id));
                        chk({p, "rdata"},   64'(rsp_rdata[g]), 64'(e.data));
                        chk({p, "rsp_vec"}, 64'(rsp_vec[g]),
                            64'((e.id < 3) ? (3'b001 << e.id) : 3'b000));
                        last_rdata = rsp_rdata[g];
                        last_id    = rsp_id[g];
                        last_vec   = rsp_vec[g];
                        last_lat   = cyc - e.k;
                    end
                end else begin
                    chk({p, "idle_vec"}, 64'(rsp_vec[g]), 64'(0));
                    if (rq.size() > 0 && rq[0].k + L <= cyc) begin
                        chk({p, "missing_rsp"}, 64'(0), 64'(1));
                        void'(rq.pop_front());
                    end
                end
                if (in_valid[g] && in_ready[g]) begin
                    e.k = cyc + 1;
                    e.we = in_we[g];
                    e.addr = in_addr[g];
                    e.be = in_be[g];
                    e.data = in_wdata[g];
                    e.id = in_id[g];
                    ops.push_back(e);
                    if (e.we) begin
                        pw.push_back(e);
                    end else begin
                        d = mem.exists(int'(e.addr)) ? mem[int'(e.addr)] : 32'h0;
                        foreach (pw[i]) if (pw[i].addr == e.addr) d = merge(d, pw[i].data, pw[i].be);
                        e.data = d;
                        rq.push_back(e);
                    end
                end
            end
        end
    end

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge
    task automatic issue(input int g, input logic we, input logic [3:0] be,
                         input logic [12:0] addr, input logic [31:0] data, input logic [1:0] id);
        int unsigned n;
        n = 0;
        in_valid[g] = 1'b1;
        in_we[g]    = we;
        in_be[g]    = be;
        in_addr[g]  = addr;
        in_wdata[g] = data;
        in_id[g]    = id;
        forever begin
            @(negedge clk);
            if (in_ready[g]) break;
            n++;
            if (n > 200) begin
                chk($sformatf("d%0d_accept_timeout", g), 64'(0), 64'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid[g] = 1'b0;
    endtask

    initial begin
        int unsigned t0;
        in_valid = '0;
        in_we = '0;
        in_be = '0;
        in_addr = '0;
        in_wdata = '0;
        in_id = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int g = 0; g < NDUT; g++)
            for (int unsigned a = 0; a < 16; a++)
                issue(g, 1'b1, 4'hF, 13'(a), pre(a), 2'(REQ_DMA));
        idle(40);

        // Back-to-back reads beyond the in-flight limit
        t0 = cyc;
        for (int unsigned i = 0; i < 8; i++) issue(0, 1'b0, 4'h0, 13'(i), 32'h0, 2'(REQ_CPU));
        chk("burst_first8_cycles", 64'(cyc - t0), 64'(8));
        for (int unsigned i = 8; i < 12; i++) issue(0, 1'b0, 4'h0, 13'(i), 32'h0, 2'(REQ_CPU));
        chk("burst_all12_cycles", 64'(cyc - t0), 64'(16));
        idle(15);
        chk("burst_peak", 64'(g_dut[0].peak), 64'(8));
        chk("burst_last_data", 64'(g_dut[0].last_rdata), 64'(pre(11)));

        // Write then read next cycle
        issue(0, 1'b1, 4'hF, 13'd5, 32'hDEADBEEF, 2'(REQ_DMA));
        issue(0, 1'b0, 4'h0, 13'd5, 32'h0, 2'(REQ_CPU));
        idle(12);
        chk("wr_rd_data", 64'(g_dut[0].last_rdata), 64'(32'hDEADBEEF));
        chk("wr_rd_vec",  64'(g_dut[0].last_vec),   64'(3'b010));
        chk("wr_rd_lat",  64'(g_dut[0].last_lat),   64'(10));

        // Partial byte write merge
        issue(0, 1'b1, 4'hF, 13'd7, 32'h11223344, 2'(REQ_DMA));
        issue(0, 1'b1, 4'b0101, 13'd7, 32'hAABBCCDD, 2'(REQ_DMA));
        issue(0, 1'b0, 4'h0, 13'd7, 32'h0, 2'(REQ_PRED));
        idle(12);
        chk("byte_merge", 64'(g_dut[0].last_rdata), 64'(32'h11BB33DD));

        // Out-of-range requester id
        issue(0, 1'b0, 4'h0, 13'd3, 32'h0, 2'd3);
        idle(12);
        chk("bad_id_vec", 64'(g_dut[0].last_vec), 64'(3'b000));
        chk("bad_id_id",  64'(g_dut[0].last_id),  64'(3));

        // Reset while a write and a read are in flight
        issue(0, 1'b1, 4'hF, 13'd9, 32'h55, 2'(REQ_DMA));
        issue(0, 1'b0, 4'h0, 13'd9, 32'h0, 2'(REQ_CPU));
        idle(4);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(40);
        chk("post_rst_out", 64'(outstanding[0]), 64'(0));
        issue(0, 1'b0, 4'h0, 13'd9, 32'h0, 2'(REQ_CPU));
        idle(12);
        chk("post_rst_mem", 64'(g_dut[0].last_rdata), 64'(pre(9)));

        // Latency extremes
        issue(1, 1'b0, 4'h0, 13'd2, 32'h0, 2'(REQ_DMA));
        idle(5);
        chk("lat2", 64'(g_dut[1].last_lat), 64'(2));
        chk("lat2_data", 64'(g_dut[1].last_rdata), 64'(pre(2)));
        issue(2, 1'b0, 4'h0, 13'd4, 32'h0, 2'(REQ_DMA));
        idle(36);
        chk("lat32", 64'(g_dut[2].last_lat), 64'(32));
        chk("lat32_data", 64'(g_dut[2].last_rdata), 64'(pre(4)));

        // Randomized mixed traffic
        for (int g = 0; g < NDUT; g++) begin
            repeat (120) begin
                issue(g, 1'($urandom_range(0, 1)), 4'($urandom), 13'($urandom_range(0, 15)),
                      $urandom, 2'($urandom_range(0, 3)));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
            idle(lat_of(g) + 5);
        end

        chk("drain0", 64'(g_dut[0].rq.size()), 64'(0));
        chk("drain1", 64'(g_dut[1].rq.size()), 64'(0));
        chk("drain2", 64'(g_dut[2].rq.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
